// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory port, decode handshake and redirect/halt signals.
// The master modport is the fetch unit; the slave modport is the memory/decode/execute side.
interface instr_fetch_unit_if #(
    parameter int unsigned INSTR_W = 32,
    parameter int unsigned PC_W    = 10
);
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc_out;
    logic [4:0]         opcode;
    logic               rd_type;
    logic               rs1_type;
    logic               rs2_type;
    logic               branch_taken;
    logic [PC_W-1:0]    branch_target;
    logic               halted;

    modport master (
        output imem_req, imem_addr, out_valid, instr, pc_out, opcode,
        output rd_type, rs1_type, rs2_type, halted,
        input  imem_rdata, out_ready, branch_taken, branch_target
    );

    modport slave (
        input  imem_req, imem_addr, out_valid, instr, pc_out, opcode,
        input  rd_type, rs1_type, rs2_type, halted,
        output imem_rdata, out_ready, branch_taken, branch_target
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: credit-based prefetch into a small FIFO, branch redirect, sticky halt.
// Define FETCH_PERF_CNT_EN to add the fetch_count / stall_count performance counters.
module instr_fetch_unit #(
    parameter int unsigned INSTR_W    = 32,
    parameter int unsigned PC_W       = 10,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned RESET_PC   = 0
) (
    input  logic clk,
    input  logic rst,
    instr_fetch_unit_if.master bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0] fetch_count,
    output logic [15:0] stall_count
`endif
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [1:0] {StRun, StRedir, StHalt} state_e;

    state_e             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    req_pc_q, req_pc_d;
    logic               inflight_q, inflight_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [INSTR_W-1:0] instr_mem_q [FIFO_DEPTH];
    logic [INSTR_W-1:0] instr_mem_d [FIFO_DEPTH];
    logic [PC_W-1:0]    pc_mem_q [FIFO_DEPTH];
    logic [PC_W-1:0]    pc_mem_d [FIFO_DEPTH];

    logic [INSTR_W-1:0] head_instr;
    logic               out_valid, pop, halt_pop, push, flush, req;
    logic [CntW:0]      occ;

    assign head_instr = instr_mem_q[rd_ptr_q];
    assign out_valid  = (cnt_q != '0) && (state_q == StRun);
    assign pop        = out_valid && bus.out_ready;
    assign halt_pop   = pop && (head_instr[31:27] == 5'b00000);

    // Buffered entries plus the outstanding response must never exceed the FIFO depth.
    assign occ = {1'b0, cnt_q} + (CntW+1)'(inflight_q) - (CntW+1)'(pop);
    assign req = !rst && (state_q == StRun) && (occ < (CntW+1)'(FIFO_DEPTH));

    assign bus.imem_req  = req;
    assign bus.imem_addr = pc_q;
    assign bus.out_valid = out_valid;
    assign bus.instr     = head_instr;
    assign bus.pc_out    = pc_mem_q[rd_ptr_q];
    assign bus.opcode    = head_instr[31:27];
    assign bus.rd_type   = head_instr[26];
    assign bus.rs1_type  = head_instr[25];
    assign bus.rs2_type  = head_instr[24];
    assign bus.halted    = (state_q == StHalt);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = req;
        push       = 1'b0;
        flush      = 1'b0;
        unique case (state_q)
            StRun: begin
                if (halt_pop) begin
                    state_d = StHalt;
                    flush   = 1'b1;
                end else if (bus.branch_taken) begin
                    flush   = 1'b1;
                    pc_d    = bus.branch_target;
                    // A request issued this cycle returns next cycle and must be drained.
                    state_d = req ? StRedir : StRun;
                end else begin
                    push = inflight_q;
                    if (req) begin
                        pc_d     = pc_q + 1'b1;
                        req_pc_d = pc_q;
                    end
                end
            end
            StRedir: state_d = StRun;
            StHalt:  state_d = StHalt;
            default: state_d = StRun;
        endcase
    end

    always_comb begin
        instr_mem_d = instr_mem_q;
        pc_mem_d    = pc_mem_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        cnt_d       = cnt_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) begin
                instr_mem_d[wr_ptr_q] = bus.imem_rdata;
                pc_mem_d[wr_ptr_q]    = req_pc_q;
                wr_ptr_d              = wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
            cnt_d = cnt_q + CntW'(push) - CntW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StRun;
            pc_q        <= PC_W'(RESET_PC);
            req_pc_q    <= '0;
            inflight_q  <= 1'b0;
            cnt_q       <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            instr_mem_q <= '{default: '0};
            pc_mem_q    <= '{default: '0};
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            inflight_q  <= inflight_d;
            cnt_q       <= cnt_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            instr_mem_q <= instr_mem_d;
            pc_mem_q    <= pc_mem_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetch_count_q, fetch_count_d, stall_count_q, stall_count_d;

    always_comb begin
        fetch_count_d = fetch_count_q;
        stall_count_d = stall_count_q;
        if (state_q != StHalt) begin
            if (pop && fetch_count_q != 16'hFFFF) fetch_count_d = fetch_count_q + 16'd1;
            if (out_valid && !bus.out_ready && stall_count_q != 16'hFFFF) begin
                stall_count_d = stall_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
    assign stall_count = stall_count_q;
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit: streaming, stall, redirect, wrap, halt, reset.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_instr_fetch_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   passed = 0;
    logic [31:0] mem [1024];

    instr_fetch_unit_if #(.INSTR_W(32), .PC_W(10)) bus ();

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetch_count, stall_count;
    instr_fetch_unit #(.INSTR_W(32), .PC_W(10), .FIFO_DEPTH(2), .RESET_PC(0)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .fetch_count(fetch_count), .stall_count(stall_count)
    );
`else
    instr_fetch_unit #(.INSTR_W(32), .PC_W(10), .FIFO_DEPTH(2), .RESET_PC(0)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
`endif

    always #5 clk = ~clk;

    // Memory model: data valid the cycle after the request.
    always @(posedge clk) if (bus.imem_req) bus.imem_rdata <= mem[bus.imem_addr];

    function automatic logic [31:0] word(input logic [9:0] n);
        return {5'b11000, 3'b000, 24'(n)};
    endfunction

    task automatic fill_mem();
        for (int i = 0; i < 1024; i++) mem[i] = word(10'(i));
    endtask

    // Leaves the bench 1 time unit after release on a falling edge (cycle 0).
    task automatic do_reset();
        bus.branch_taken  = 1'b0;
        bus.branch_target = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", bus.out_valid); else passed++;
        total++; if (bus.imem_req !== 1'b0) $display("FAIL reset_req got %b exp 0", bus.imem_req); else passed++;
        total++; if (bus.halted !== 1'b0) $display("FAIL reset_halted got %b exp 0", bus.halted); else passed++;
        total++; if (bus.instr !== 32'h0 || bus.pc_out !== 10'h0 || bus.opcode !== 5'h0)
            $display("FAIL reset_fields got instr=%h pc=%h op=%h exp 0", bus.instr, bus.pc_out, bus.opcode);
        else passed++;
    endtask

    task automatic test_stream();
        bus.out_ready = 1'b1;
        do_reset();
        @(negedge clk);
        total++; if (bus.out_valid !== 1'b0) $display("FAIL stream_c1_valid got %b exp 0", bus.out_valid); else passed++;
        @(negedge clk);
        total++; if (bus.out_valid !== 1'b1 || bus.pc_out !== 10'h0)
            $display("FAIL stream_first got valid=%b pc=%h exp valid=1 pc=000", bus.out_valid, bus.pc_out);
        else passed++;
        total++; if (bus.opcode !== 5'b11000 || {bus.rd_type, bus.rs1_type, bus.rs2_type} !== 3'b000)
            $display("FAIL stream_fields got op=%b types=%b%b%b exp 11000 000", bus.opcode,
                     bus.rd_type, bus.rs1_type, bus.rs2_type);
        else passed++;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            total++; if (bus.out_valid !== 1'b1 || bus.pc_out !== 10'(k) || bus.instr !== word(10'(k)))
                $display("FAIL stream_pc%0d got valid=%b pc=%h instr=%h exp 1 %h %h", k,
                         bus.out_valid, bus.pc_out, bus.instr, 10'(k), word(10'(k)));
            else passed++;
        end
    endtask

    task automatic test_stall();
        int reqs;
        bus.out_ready = 1'b0;
        do_reset();
        reqs = int'(bus.imem_req);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            reqs += int'(bus.imem_req);
            if (c >= 2) begin
                total++; if (bus.out_valid !== 1'b1 || bus.pc_out !== 10'h0 || bus.instr !== word(10'h0))
                    $display("FAIL stall_hold_c%0d got valid=%b pc=%h exp 1 000", c, bus.out_valid, bus.pc_out);
                else passed++;
            end
        end
        total++; if (reqs > 2) $display("FAIL stall_reads got %0d exp <=2", reqs); else passed++;
        bus.out_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            total++; if (bus.out_valid !== 1'b1 || bus.pc_out !== 10'(k))
                $display("FAIL stall_release_pc%0d got valid=%b pc=%h exp 1 %h", k, bus.out_valid,
                         bus.pc_out, 10'(k));
            else passed++;
        end
    endtask

    task automatic test_branch();
        bus.out_ready = 1'b1;
        do_reset();
        repeat (3) @(negedge clk);
        total++; if (bus.pc_out !== 10'h1) $display("FAIL branch_pre got pc=%h exp 001", bus.pc_out); else passed++;
        bus.branch_taken  = 1'b1;
        bus.branch_target = 10'h100;
        @(negedge clk);
        bus.branch_taken = 1'b0;
        total++; if (bus.out_valid !== 1'b0 || bus.imem_req !== 1'b0)
            $display("FAIL branch_redir got valid=%b req=%b exp 0 0", bus.out_valid, bus.imem_req);
        else passed++;
        @(negedge clk);
        total++; if (bus.out_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 10'h100)
            $display("FAIL branch_req got valid=%b req=%b addr=%h exp 0 1 100", bus.out_valid,
                     bus.imem_req, bus.imem_addr);
        else passed++;
        @(negedge clk);
        total++; if (bus.out_valid !== 1'b0) $display("FAIL branch_gap got %b exp 0", bus.out_valid); else passed++;
        @(negedge clk);
        total++; if (bus.out_valid !== 1'b1 || bus.pc_out !== 10'h100 || bus.instr !== word(10'h100))
            $display("FAIL branch_target got valid=%b pc=%h instr=%h exp 1 100 %h", bus.out_valid,
                     bus.pc_out, bus.instr, word(10'h100));
        else passed++;
        @(negedge clk);
        total++; if (bus.out_valid !== 1'b1 || bus.pc_out !== 10'h101)
            $display("FAIL branch_next got valid=%b pc=%h exp 1 101", bus.out_valid, bus.pc_out);
        else passed++;
    endtask

    task automatic test_wrap();
        bus.out_ready = 1'b1;
        do_reset();
        repeat (2) @(negedge clk);
        bus.branch_taken  = 1'b1;
        bus.branch_target = 10'h3FF;
        @(negedge clk);
        bus.branch_taken = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (bus.out_valid !== 1'b1 || bus.pc_out !== 10'h3FF || bus.instr !== word(10'h3FF))
            $display("FAIL wrap_last got valid=%b pc=%h exp 1 3ff", bus.out_valid, bus.pc_out);
        else passed++;
        @(negedge clk);
        total++; if (bus.out_valid !== 1'b1 || bus.pc_out !== 10'h000 || bus.instr !== word(10'h000))
            $display("FAIL wrap_zero got valid=%b pc=%h exp 1 000", bus.out_valid, bus.pc_out);
        else passed++;
    endtask

    task automatic test_halt();
        mem[4] = 32'h0;
        bus.out_ready = 1'b1;
        do_reset();
        repeat (6) @(negedge clk);
        total++; if (bus.out_valid !== 1'b1 || bus.pc_out !== 10'h4 || bus.opcode !== 5'b00000)
            $display("FAIL halt_head got valid=%b pc=%h op=%b exp 1 004 00000", bus.out_valid,
                     bus.pc_out, bus.opcode);
        else passed++;
        bus.out_ready = 1'b0;
        @(negedge clk);
        total++; if (bus.halted !== 1'b0 || bus.pc_out !== 10'h4)
            $display("FAIL halt_unpopped got halted=%b pc=%h exp 0 004", bus.halted, bus.pc_out);
        else passed++;
        bus.out_ready = 1'b1;
        @(negedge clk);
        total++; if (bus.halted !== 1'b1 || bus.out_valid !== 1'b0 || bus.imem_req !== 1'b0)
            $display("FAIL halt_enter got halted=%b valid=%b req=%b exp 1 0 0", bus.halted,
                     bus.out_valid, bus.imem_req);
        else passed++;
        bus.branch_taken  = 1'b1;
        bus.branch_target = 10'h050;
        @(negedge clk);
        bus.branch_taken = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (bus.halted !== 1'b1 || bus.out_valid !== 1'b0 || bus.imem_req !== 1'b0)
            $display("FAIL halt_sticky got halted=%b valid=%b req=%b exp 1 0 0", bus.halted,
                     bus.out_valid, bus.imem_req);
        else passed++;
        do_reset();
        total++; if (bus.halted !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 10'h0)
            $display("FAIL halt_exit got halted=%b req=%b addr=%h exp 0 1 000", bus.halted,
                     bus.imem_req, bus.imem_addr);
        else passed++;
        mem[4] = word(10'h4);
    endtask

    task automatic test_async_reset();
        bus.out_ready = 1'b0;
        do_reset();
        repeat (4) @(negedge clk);
        total++; if (bus.out_valid !== 1'b1) $display("FAIL arst_pre got valid=%b exp 1", bus.out_valid); else passed++;
        #2 rst = 1'b1;
        #1;
        total++; if (bus.out_valid !== 1'b0 || bus.imem_req !== 1'b0 || bus.instr !== 32'h0)
            $display("FAIL arst_immediate got valid=%b req=%b instr=%h exp 0 0 0", bus.out_valid,
                     bus.imem_req, bus.instr);
        else passed++;
        bus.out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 10'h0)
            $display("FAIL arst_restart got req=%b addr=%h exp 1 000", bus.imem_req, bus.imem_addr);
        else passed++;
        repeat (2) @(negedge clk);
        total++; if (bus.out_valid !== 1'b1 || bus.pc_out !== 10'h0)
            $display("FAIL arst_first got valid=%b pc=%h exp 1 000", bus.out_valid, bus.pc_out);
        else passed++;
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_perf();
        bus.out_ready = 1'b0;
        do_reset();
        total++; if (fetch_count !== 16'd0 || stall_count !== 16'd0)
            $display("FAIL perf_reset got fetch=%0d stall=%0d exp 0 0", fetch_count, stall_count);
        else passed++;
        repeat (5) @(negedge clk);
        bus.out_ready = 1'b1;
        repeat (4) @(negedge clk);
        bus.out_ready = 1'b0;
        total++; if (stall_count !== 16'd3) $display("FAIL perf_stall got %0d exp 3", stall_count); else passed++;
        total++; if (fetch_count !== 16'd4) $display("FAIL perf_fetch got %0d exp 4", fetch_count); else passed++;
    endtask
`endif

    initial begin
        bus.out_ready     = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = '0;
        bus.imem_rdata    = '0;
        fill_mem();
        test_reset();
        test_stream();
        test_stall();
        test_branch();
        test_wrap();
        test_halt();
        test_async_reset();
`ifdef FETCH_PERF_CNT_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no finish exp finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Producer side of the instruction decoder interface. Fetches 32-bit instructions from instruction memory and buffers them in a small prefetch FIFO.
- Presents each instruction to the decode stage over a valid/ready handshake, with the opcode and the three operand-type bits pre-extracted.
- Handles branch redirect (flush plus new PC) and a sticky halt.

Parameters:
- INSTR_W, 32, instruction width; fields defined for 32 only.
- PC_W, 10, word-address width of the PC; wraps modulo 2^PC_W.
- FIFO_DEPTH, 2, prefetch entries; power of two, ≥2.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- imem_req  out  1  read strobe to instruction memory.
- imem_addr  out  PC_W  word address of the read.
- imem_rdata  in  INSTR_W  read data; valid exactly 1 cycle after imem_req.
- out_valid  out  1  instruction available to decode.
- out_ready  in  1  decode accepts this cycle.
- instr  out  INSTR_W  head instruction.
- pc_out  out  PC_W  address of the head instruction.
- opcode  out  5  instr[31:27] (decoder OpCode).
- rd_type, rs1_type, rs2_type  out  1 each  instr[26], instr[25], instr[24].
- branch_taken  in  1  redirect request from execute.
- branch_target  in  PC_W  redirect address.
- halted  out  1  halt instruction consumed; fetch stopped.

Behaviour:
- Reset, asynchronous, any cycle including mid-fetch:
  - PC = RESET_PC; FIFO empty; in-flight flag clear.
  - imem_req = 0, out_valid = 0, halted = 0.
  - instr, pc_out and all fields = 0.
- States:
  - RUN: normal fetch.
  - REDIR: one cycle, drains the in-flight response.
  - HALT: sticky.
  - Reset enters RUN.
- RUN fetch rule:
  - imem_req = 1 when (occupancy + inflight) < FIFO_DEPTH, or when a pop this cycle frees a slot.
  - imem_addr = PC, then PC = PC+1 with wrap (2^PC_W−1 goes to 0).
  - A response arriving the cycle after a request is pushed together with its PC.
  - Credit accounting guarantees no overflow; a response is never dropped in RUN.
- Handshake:
  - A pop occurs when out_valid && out_ready.
  - instr, pc_out and the fields are stable while out_valid=1 and out_ready=0.
  - Simultaneous push and pop is allowed when full.
  - A response landing in an empty FIFO is visible on out_valid the cycle after imem_rdata is valid. Minimum latency from request to out_valid is 2 cycles.
  - Steady state delivers 1 instruction per cycle with out_ready held at 1.
- Redirect, when branch_taken=1 in RUN:
  - FIFO is flushed the same edge; out_valid = 0 next cycle.
  - PC = branch_target.
  - Any response still in flight is discarded (REDIR state, imem_req = 0 that cycle if a response is pending). Otherwise the first request to branch_target is issued the next cycle.
  - A pop coincident with branch_taken still counts as accepted.
  - branch_taken has priority over pushes.
- Halt:
  - Triggered when an instruction with opcode 5'b00000 is popped.
  - Next edge: halted = 1, FIFO flushed, imem_req = 0, out_valid = 0.
  - Subsequent branch_taken is ignored. Only rst exits HALT.
  - A halt opcode sitting unpopped in the FIFO has no effect.
- Halt pop coincident with branch_taken: halt wins.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined, two extra output ports are added:
  - fetch_count [15:0]: number of pops.
  - stall_count [15:0]: cycles with out_valid=1 and out_ready=0.
- Both counters saturate at 16'hFFFF, reset to 0, and freeze in HALT.
- When undefined, neither the ports nor the logic exist; all other behaviour is identical.

Test Plan:
- Memory word n = {5'b11000, 3'b000, n[23:0]}, out_ready=1 from reset release → first out_valid at cycle 2 with pc_out=0. Then one instruction per cycle, pc_out 0,1,2,…; opcode=5'b11000, types 0.
- out_ready=0 for 5 cycles after the first valid → at most FIFO_DEPTH reads issued, instr/pc_out held at pc 0. On release, pc 1 and 2 follow with no gaps or duplicates.
- branch_taken=1 with branch_target=10'h100 while a response is in flight → the in-flight word is never presented, the FIFO is flushed, and the next valid has pc_out=10'h100.
- Halt: word at pc 4 = 32'h0 → after it is popped, halted=1 next cycle and imem_req stays 0. A later branch_taken has no effect; rst restores PC=RESET_PC and halted=0.
- PC wrap: branch_target=10'h3FF → consecutive pc_out 10'h3FF then 10'h000.
- rst pulsed mid-stream with 2 entries buffered → out_valid=0 immediately (asynchronous). After release, fetch restarts at RESET_PC.
- (With FETCH_PERF_CNT_EN) 3 stall cycles then 4 pops → stall_count=3, fetch_count=4.
